// File: rtl/srt_div_arb.sv
// ---------------------------------------------------------------------------
// srt_div_arb
//   Round-robin arbiter and sequencer sharing one multi-cycle divider among
//   NREQ requesters. One operation is in flight at a time: a request is
//   accepted in IDLE, launched to the divider with a one-cycle start pulse,
//   and its result is returned over a valid/ready response channel tagged
//   with the requester id. A zero divisor is answered locally
//   (quo = all ones, rem = dividend, dz = 1) without starting the divider.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o per-requester handshake (at most one ready set)
//   req_op1_i / req_op2_i     packed dividends / divisors, slice k = [k*WIDTH +: WIDTH]
//   rsp_valid_o / rsp_ready_i response handshake
//   rsp_id_o, rsp_quo_o,
//   rsp_rem_o, rsp_dz_o       response payload
//   div_start_o               one-cycle start pulse to the divider
//   div_op1_o / div_op2_o     operands, stable from start until done
//   div_done_i                divider completion pulse, results valid this cycle
//   div_quo_i / div_rem_i     divider results
// ---------------------------------------------------------------------------
module srt_div_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [NREQ*WIDTH-1:0]   req_op1_i,
    input  logic [NREQ*WIDTH-1:0]   req_op2_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [$clog2(NREQ)-1:0] rsp_id_o,
    output logic [WIDTH-1:0]        rsp_quo_o,
    output logic [WIDTH-1:0]        rsp_rem_o,
    output logic                    rsp_dz_o,
    output logic                    div_start_o,
    output logic [WIDTH-1:0]        div_op1_o,
    output logic [WIDTH-1:0]        div_op2_o,
    input  logic                    div_done_i,
    input  logic [WIDTH-1:0]        div_quo_i,
    input  logic [WIDTH-1:0]        div_rem_i
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   cand;
    logic             grant_vld;
    logic [WIDTH-1:0] sel_op1;
    logic [WIDTH-1:0] sel_op2;

    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dz;

    logic             req_fire;
    logic             rsp_fire;
    logic             div_fire;

    // Round-robin search starting at rr_ptr; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((32'(rr_ptr) + 32'(i)) % 32'(NREQ));
            if (!grant_vld && req_valid_i[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_op1 = '0;
        sel_op2 = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == grant) begin
                sel_op1 = req_op1_i[k*WIDTH +: WIDTH];
                sel_op2 = req_op2_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign req_fire = (state == IDLE) && grant_vld;
    assign rsp_fire = (state == RESP) && rsp_ready_i;
    // Completion pulses outside WAIT are ignored.
    assign div_fire = (state == WAIT) && div_done_i;

    always_comb begin
        req_ready_o = '0;
        if (req_fire) begin
            req_ready_o[grant] = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    state_next = (sel_op2 == '0) ? RESP : ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT:    if (div_done_i) state_next = RESP;
            RESP:    if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand, result and round-robin pointer registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
            id     <= '0;
            op1    <= '0;
            op2    <= '0;
            quo    <= '0;
            rem    <= '0;
            dz     <= 1'b0;
        end else begin
            if (req_fire) begin
                id  <= grant;
                op1 <= sel_op1;
                op2 <= sel_op2;
                // Divide-by-zero is answered without the divider.
                if (sel_op2 == '0) begin
                    quo <= '1;
                    rem <= sel_op1;
                    dz  <= 1'b1;
                end
            end
            if (div_fire) begin
                quo <= div_quo_i;
                rem <= div_rem_i;
                dz  <= 1'b0;
            end
            // Pointer moves past the requester just answered, wrapping at NREQ-1.
            if (rsp_fire) begin
                rr_ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
            end
        end
    end

    assign div_start_o = (state == ISSUE);
    assign div_op1_o   = op1;
    assign div_op2_o   = op2;

    assign rsp_valid_o = (state == RESP);
    assign rsp_id_o    = id;
    assign rsp_quo_o   = quo;
    assign rsp_rem_o   = rem;
    assign rsp_dz_o    = dz;

endmodule

// File: tb/tb_srt_div_arb.sv
// ---------------------------------------------------------------------------
// tb_srt_div_arb
//   Directed plus randomized bench for srt_div_arb. A behavioural divider
//   with programmable latency answers start pulses; a reference model
//   predicts the round-robin grant, the result and the response latency.
// ---------------------------------------------------------------------------
module tb_srt_div_arb;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk;
    logic              rstn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_op1;
    logic [NREQ*W-1:0] req_op2;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_quo;
    logic [W-1:0]      rsp_rem;
    logic              rsp_dz;
    logic              div_start;
    logic [W-1:0]      div_op1;
    logic [W-1:0]      div_op2;
    logic              div_done;
    logic [W-1:0]      div_quo;
    logic [W-1:0]      div_rem;

    logic              mdone;
    logic              stray_done;
    int                div_lat;
    int                start_cnt;

    int                checks;
    int                errors;
    int                exp_ptr;

    srt_div_arb #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op1_i   (req_op1),
        .req_op2_i   (req_op2),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_quo_o   (rsp_quo),
        .rsp_rem_o   (rsp_rem),
        .rsp_dz_o    (rsp_dz),
        .div_start_o (div_start),
        .div_op1_o   (div_op1),
        .div_op2_o   (div_op2),
        .div_done_i  (div_done),
        .div_quo_i   (div_quo),
        .div_rem_i   (div_rem)
    );

    assign div_done = mdone | stray_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Behavioural divider: done arrives div_lat cycles after the start cycle.
    initial begin : divider_model
        int a;
        int b;
        mdone     = 1'b0;
        div_quo   = '0;
        div_rem   = '0;
        start_cnt = 0;
        forever begin
            @(negedge clk);
            if (rstn && div_start) begin
                start_cnt++;
                a = int'(div_op1);
                b = int'(div_op2);
                repeat (div_lat) @(posedge clk);
                #1;
                div_quo = W'(a / b);
                div_rem = W'(a % b);
                mdone   = 1'b1;
                @(posedge clk);
                #1;
                mdone = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int a, input int b);
        req_op1[k*W +: W] = W'(a);
        req_op2[k*W +: W] = W'(b);
        req_valid[k]      = 1'b1;
    endtask

    // Runs one complete operation from IDLE with the current request vector.
    // hold: cycles rsp_ready stays low; keep: granted requester keeps valid.
    task automatic run_op(input int hold, input bit keep, output int gid);
        int g;
        int a;
        int b;
        int exq;
        int exr;
        int t;
        int sc0;
        #1;
        g = -1;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (exp_ptr + i) % NREQ;
            if (g < 0 && req_valid[k]) g = k;
        end
        gid = g;
        if (g < 0) begin
            check("no_valid_request", 32'(req_valid), 32'(1));
            return;
        end
        a   = int'(req_op1[g*W +: W]);
        b   = int'(req_op2[g*W +: W]);
        exq = (b == 0) ? 255 : a / b;
        exr = (b == 0) ? a : a % b;
        sc0 = start_cnt;
        check("ready_grant", 32'(req_ready), 32'(1 << g));
        tick();
        if (!keep) req_valid[g] = 1'b0;
        if (b == 0) begin
            check("dz_rsp_latency", 32'(rsp_valid), 32'(1));
            check("dz_no_start", 32'(div_start), 32'(0));
        end else begin
            check("start_pulse", 32'(div_start), 32'(1));
            check("start_op1", 32'(div_op1), 32'(a));
            check("start_op2", 32'(div_op2), 32'(b));
            check("ready_busy", 32'(req_ready), 32'(0));
            t = 0;
            while (!rsp_valid && t < 60) begin
                tick();
                t++;
            end
            check("rsp_latency", 32'(t), 32'(div_lat + 1));
            check("op1_stable", 32'(div_op1), 32'(a));
            check("op2_stable", 32'(div_op2), 32'(b));
        end
        check("rsp_valid", 32'(rsp_valid), 32'(1));
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_quo", 32'(rsp_quo), 32'(exq));
        check("rsp_rem", 32'(rsp_rem), 32'(exr));
        check("rsp_dz", 32'(rsp_dz), 32'(b == 0));
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 32'(rsp_valid), 32'(1));
            check("hold_id", 32'(rsp_id), 32'(g));
            check("hold_quo", 32'(rsp_quo), 32'(exq));
            check("hold_rem", 32'(rsp_rem), 32'(exr));
            check("hold_dz", 32'(rsp_dz), 32'(b == 0));
            check("hold_ready", 32'(req_ready), 32'(0));
            check("hold_no_start", 32'(div_start), 32'(0));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_released", 32'(rsp_valid), 32'(0));
        check("start_count", 32'(start_cnt - sc0), 32'(b != 0));
        exp_ptr = (g + 1) % NREQ;
    endtask

    initial begin : stimulus
        int g;
        int sc;
        checks     = 0;
        errors     = 0;
        exp_ptr    = 0;
        rstn       = 1'b0;
        req_valid  = '0;
        req_op1    = '0;
        req_op2    = '0;
        rsp_ready  = 1'b0;
        stray_done = 1'b0;
        div_lat    = 3;

        // Reset state
        tick();
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_start", 32'(div_start), 32'(0));
        check("rst_ready", 32'(req_ready), 32'(0));
        check("rst_op1", 32'(div_op1), 32'(0));
        check("rst_quo", 32'(rsp_quo), 32'(0));
        rstn = 1'b1;
        tick();

        // 24/5 from requester 0
        set_req(0, 24, 5);
        div_lat = 3;
        run_op(0, 1'b0, g);
        check("t1_id", 32'(g), 32'(0));

        // 7/0 from requester 2
        set_req(2, 7, 0);
        run_op(0, 1'b0, g);
        check("t2_id", 32'(g), 32'(2));

        // Bring the pointer back to 0, then all four continuously valid
        set_req(3, 50, 7);
        div_lat = 2;
        run_op(0, 1'b0, g);
        for (int k = 0; k < NREQ; k++) set_req(k, 100, k + 1);
        div_lat = 4;
        run_op(0, 1'b1, g);
        check("t3_order0", 32'(g), 32'(0));
        run_op(5, 1'b1, g);
        check("t3_order1", 32'(g), 32'(1));
        run_op(0, 1'b1, g);
        check("t3_order2", 32'(g), 32'(2));
        run_op(0, 1'b1, g);
        check("t3_order3", 32'(g), 32'(3));
        run_op(0, 1'b1, g);
        check("t3_order4", 32'(g), 32'(0));
        req_valid = '0;

        // rr_ptr=2 with requesters 1 and 3 pending
        set_req(1, 9, 2);
        div_lat = 1;
        run_op(0, 1'b0, g);
        set_req(1, 200, 9);
        set_req(3, 255, 16);
        run_op(0, 1'b0, g);
        check("t6_first", 32'(g), 32'(3));
        run_op(0, 1'b0, g);
        check("t6_second", 32'(g), 32'(1));
        for (int k = 0; k < NREQ; k++) set_req(k, 77, k + 3);
        run_op(0, 1'b0, g);
        check("t6_ptr_after", 32'(g), 32'(2));
        req_valid = '0;
        tick();

        // Reset during WAIT, then stray completion pulses in IDLE
        set_req(1, 200, 3);
        div_lat = 8;
        #1;
        tick();
        req_valid = '0;
        tick();
        tick();
        sc = start_cnt;
        rstn = 1'b0;
        #1;
        check("t5_rsp_valid", 32'(rsp_valid), 32'(0));
        check("t5_start", 32'(div_start), 32'(0));
        check("t5_op1", 32'(div_op1), 32'(0));
        check("t5_op2", 32'(div_op2), 32'(0));
        check("t5_id", 32'(rsp_id), 32'(0));
        check("t5_quo", 32'(rsp_quo), 32'(0));
        check("t5_rem", 32'(rsp_rem), 32'(0));
        check("t5_dz", 32'(rsp_dz), 32'(0));
        check("t5_ready", 32'(req_ready), 32'(0));
        exp_ptr = 0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        repeat (12) tick();
        check("t5_stray_rsp", 32'(rsp_valid), 32'(0));
        check("t5_stray_start", 32'(start_cnt - sc), 32'(0));
        set_req(0, 24, 5);
        div_lat = 3;
        run_op(0, 1'b0, g);
        check("t5_after_id", 32'(g), 32'(0));

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k] && $urandom_range(0, 1) == 1) begin
                    set_req(k, int'($urandom_range(0, 255)),
                            ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255)));
                end
            end
            if (req_valid == '0) begin
                set_req(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)));
            end
            div_lat = int'($urandom_range(1, 6));
            run_op(int'($urandom_range(0, 2)), 1'b0, g);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
